verdict_collector: RTL



---
 rtl/verdict_collector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/verdict_collector.sv
// Verdict collector: timestamps every cycle in which the monitor reports at least one
// active output, buffers it as a record and drains it as (ts, idx, value) beats.
module verdict_collector #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16,
    localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [TS_W-1:0]           rec_ts,
    output logic [IDX_W-1:0]          rec_idx,
    output logic [DATA_W-1:0]         rec_value,
    output logic                      rec_last,
    output logic                      overflow,
    output logic [15:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    // Record storage, one slot per buffered monitor cycle.
    logic [TS_W-1:0]           ts_mem   [DEPTH];
    logic [NUM_OUT-1:0]        mask_mem [DEPTH];
    logic [NUM_OUT*DATA_W-1:0] data_mem [DEPTH];

    logic [TS_W-1:0]  ts_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             overflow_q;
    logic [15:0]      drop_count_q;

    logic                      capture;
    logic                      full;
    logic                      push;
    logic                      drop;
    logic                      handshake;
    logic                      last_beat;
    logic                      pop;
    logic [NUM_OUT-1:0]        head_mask;
    logic [NUM_OUT-1:0]        next_head_mask;
    logic [NUM_OUT*DATA_W-1:0] head_data;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OUT-1:0] mask);
        lowest_set = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [IDX_W-1:0] next_set(input logic [NUM_OUT-1:0] mask,
                                                  input logic [IDX_W-1:0]   cur);
        next_set = cur;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) next_set = IDX_W'(i);
        end
    endfunction

    function automatic logic has_higher(input logic [NUM_OUT-1:0] mask,
                                        input logic [IDX_W-1:0]   cur);
        has_higher = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mask[i] && (i > int'(cur))) has_higher = 1'b1;
        end
    endfunction

    assign capture   = en && (out_aktv != '0);
    // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
    assign full      = (count_q == FULL_COUNT);
    assign push      = capture && !full;
    assign drop      = capture && full;

    assign head_mask   = mask_mem[rd_ptr_q];
    assign head_data   = data_mem[rd_ptr_q];
    assign rd_ptr_next = rd_ptr_q + PTR_W'(1);
    assign last_beat   = !has_higher(head_mask, idx_q);
    assign handshake   = (state_q == EMIT) && rec_ready;
    assign pop         = handshake && last_beat;

    // With a single record left, the next head is the one being pushed this cycle.
    assign next_head_mask = (count_q == ONE_COUNT) ? out_aktv : mask_mem[rd_ptr_next];

    assign count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = EMIT;
                    idx_d   = lowest_set(head_mask);
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (!last_beat) begin
                        idx_d = next_set(head_mask, idx_q);
                    end else if ((count_q > ONE_COUNT) || push) begin
                        idx_d = lowest_set(next_head_mask);
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (en) ts_q <= ts_q + TS_W'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_next;
            count_q <= count_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    // NOTE: the record storage has no reset; the pointers and count define which
    // entries are meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q]   <= ts_q;
            mask_mem[wr_ptr_q] <= out_aktv;
            data_mem[wr_ptr_q] <= out_data;
        end
    end

    assign rec_valid  = (state_q == EMIT);
    assign rec_ts     = rec_valid ? ts_mem[rd_ptr_q] : '0;
    assign rec_idx    = rec_valid ? idx_q : '0;
    assign rec_value  = rec_valid ? head_data[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign rec_last   = rec_valid && last_beat;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
